// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard scoreboard
package hazard_pkg;

    localparam int DEF_AW = 5;
    localparam int DEF_TW = 3;

    localparam logic [DEF_TW-1:0] TUSE_NONE = '1;
    localparam int                FWD_RF    = 0;
    localparam logic [4:0]        CP0_EPC   = 5'd14;

    typedef struct packed {
        logic              valid;
        logic [DEF_AW-1:0] a3;
        logic [DEF_TW-1:0] tnew;
        logic [DEF_AW-1:0] a1;
        logic [DEF_AW-1:0] a2;
        logic              cp0we;
        logic [4:0]        cp0rd;
        logic              md_start;
        logic              md_div;
    } slot_t;

    // A result never becomes "less ready" than available, so tnew saturates at 0.
    function automatic logic [DEF_TW-1:0] tnew_dec(input logic [DEF_TW-1:0] t);
        return (t == '0) ? t : t - 1'b1;
    endfunction

endpackage

// File: rtl/hs_match_prio.sv
// rtl/hs_match_prio.sv - youngest-first register match over the stage slots
module hs_match_prio #(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int TW     = 3,
    parameter int FW     = $clog2(NSTAGE+1)
) (
    input  logic [NSTAGE-1:0]    en,
    input  logic [NSTAGE*AW-1:0] a3,
    input  logic [NSTAGE*TW-1:0] tnew,
    input  logic [AW-1:0]        src,
    output logic                 hit,
    output logic [FW-1:0]        k,
    output logic [TW-1:0]        tnew_hit
);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit      = 1'b0;
        k        = '0;
        tnew_hit = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (en[i] && a3[i*AW +: AW] == src && src != '0) begin
                hit      = 1'b1;
                k        = FW'(i + 1);
                tnew_hit = tnew[i*TW +: TW];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight writer scoreboard: D stall, D/E forward selects, MDU busy
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int AW       = DEF_AW,
    parameter int TW       = DEF_TW,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    localparam int FW      = $clog2(NSTAGE+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [AW-1:0] d_a1,
    input  logic [AW-1:0] d_a2,
    input  logic [TW-1:0] d_tuse1,
    input  logic [TW-1:0] d_tuse2,
    input  logic [AW-1:0] d_a3,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    input  logic          d_eret,
    input  logic          d_cp0we,
    input  logic [4:0]    d_cp0rd,
    output logic          stall,
    output logic [FW-1:0] fwd_d1,
    output logic [FW-1:0] fwd_d2,
    output logic [FW-1:0] fwd_e1,
    output logic [FW-1:0] fwd_e2,
    output logic          md_busy
);

    localparam int MAXLAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    slot_t slots [NSTAGE];
    slot_t aged  [NSTAGE-1];
    slot_t d_slot;
    logic [CW-1:0] md_cnt;

    logic [NSTAGE-1:0]    vld, vld_e;
    logic [NSTAGE*AW-1:0] a3_v;
    logic [NSTAGE*TW-1:0] tn_v;

    logic          hit_d1, hit_d2, hit_e1, hit_e2;
    logic [FW-1:0] k_d1, k_d2, k_e1, k_e2;
    logic [TW-1:0] tn_d1, tn_d2, tn_e1, tn_e2;
    logic          src_stall1, src_stall2, md_stall, cp0_hazard;

    always_comb begin
        vld  = '0;
        a3_v = '0;
        tn_v = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            vld[i]            = slots[i].valid;
            a3_v[i*AW +: AW]  = slots[i].a3;
            tn_v[i*TW +: TW]  = slots[i].tnew;
        end
        // E-stage operands only look at strictly older instructions.
        vld_e    = vld;
        vld_e[0] = 1'b0;
    end

    hs_match_prio #(.NSTAGE(NSTAGE), .AW(AW), .TW(TW), .FW(FW)) u_match_d1 (
        .en(vld), .a3(a3_v), .tnew(tn_v), .src(d_a1), .hit(hit_d1), .k(k_d1), .tnew_hit(tn_d1));
    hs_match_prio #(.NSTAGE(NSTAGE), .AW(AW), .TW(TW), .FW(FW)) u_match_d2 (
        .en(vld), .a3(a3_v), .tnew(tn_v), .src(d_a2), .hit(hit_d2), .k(k_d2), .tnew_hit(tn_d2));
    hs_match_prio #(.NSTAGE(NSTAGE), .AW(AW), .TW(TW), .FW(FW)) u_match_e1 (
        .en(vld_e), .a3(a3_v), .tnew(tn_v), .src(slots[0].a1), .hit(hit_e1), .k(k_e1), .tnew_hit(tn_e1));
    hs_match_prio #(.NSTAGE(NSTAGE), .AW(AW), .TW(TW), .FW(FW)) u_match_e2 (
        .en(vld_e), .a3(a3_v), .tnew(tn_v), .src(slots[0].a2), .hit(hit_e2), .k(k_e2), .tnew_hit(tn_e2));

    always_comb begin
        cp0_hazard = 1'b0;
        for (int i = 0; i < NSTAGE - 1; i++) begin
            if (slots[i].valid && slots[i].cp0we && slots[i].cp0rd == CP0_EPC)
                cp0_hazard = 1'b1;
        end
    end

    assign md_busy    = (md_cnt != '0);
    assign src_stall1 = (d_tuse1 != TUSE_NONE) && hit_d1 && (tn_d1 > d_tuse1);
    assign src_stall2 = (d_tuse2 != TUSE_NONE) && hit_d2 && (tn_d2 > d_tuse2);
    assign md_stall   = d_md_use && (md_busy || (slots[0].valid && slots[0].md_start));
    assign stall      = src_stall1 || src_stall2 || md_stall || (d_eret && cp0_hazard);

    assign fwd_d1 = (hit_d1 && tn_d1 == '0) ? k_d1 : FW'(FWD_RF);
    assign fwd_d2 = (hit_d2 && tn_d2 == '0) ? k_d2 : FW'(FWD_RF);
    assign fwd_e1 = (hit_e1 && tn_e1 == '0) ? k_e1 : FW'(FWD_RF);
    assign fwd_e2 = (hit_e2 && tn_e2 == '0) ? k_e2 : FW'(FWD_RF);

    always_comb begin
        d_slot          = '0;
        d_slot.valid    = 1'b1;
        d_slot.a3       = d_a3;
        d_slot.tnew     = d_tnew;
        d_slot.a1       = d_a1;
        d_slot.a2       = d_a2;
        d_slot.cp0we    = d_cp0we;
        d_slot.cp0rd    = d_cp0rd;
        d_slot.md_start = d_md_start;
        d_slot.md_div   = d_md_div;
        for (int i = 0; i < NSTAGE - 1; i++) begin
            aged[i]      = slots[i];
            aged[i].tnew = tnew_dec(slots[i].tnew);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < NSTAGE; i++)
                slots[i] <= '0;
        end else begin
            slots[0] <= stall ? '0 : d_slot;
            for (int i = 1; i < NSTAGE; i++)
                slots[i] <= aged[i-1];
        end
    end

    // The MDU runs on independently of pipeline flushes and stalls.
    always_ff @(posedge clk) begin
        if (reset)
            md_cnt <= '0;
        else if (slots[0].valid && slots[0].md_start)
            md_cnt <= slots[0].md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

endmodule
